// File: rtl/video_path_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_path_pkg
// Brief   : Mode count, FSM states and the index-to-address map shared with the mux.
// Revision: 1.0
// ============================================================================
package video_path_pkg;

    localparam int         NUM_MODES = 13;
    localparam logic [3:0] MODE_MAX  = 4'd12;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } path_state_t;

    // Codes 9 and 10 are swapped relative to the index on purpose.
    function automatic logic [3:0] mode_to_adres(input logic [3:0] idx);
        logic [3:0] w_adres;
        case (idx)
            4'd9:    w_adres = 4'b1010;
            4'd10:   w_adres = 4'b1001;
            4'd11:   w_adres = 4'b1011;
            4'd12:   w_adres = 4'b1111;
            default: w_adres = (idx <= 4'd8) ? idx : 4'b0000;
        endcase
        return w_adres;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_path_select_if.sv
`default_nettype none
// ============================================================================
// Module  : video_path_select_if
// Brief   : Button, sync and path-select signals between the controller and its peers.
// Revision: 1.0
// ============================================================================
interface video_path_select_if;

    logic       btn_next;
    logic       btn_prev;
    logic       v_sync_in;
    logic [3:0] adres_out;
    logic [3:0] mode_idx;
    logic       pending;
    logic       commit_pulse;

    modport master (
        input  btn_next, btn_prev, v_sync_in,
        output adres_out, mode_idx, pending, commit_pulse
    );

    modport slave (
        output btn_next, btn_prev, v_sync_in,
        input  adres_out, mode_idx, pending, commit_pulse
    );

endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : button_debounce
// Brief   : Accepts a new level after DEBOUNCE_CYCLES stable samples; flags presses.
// Revision: 1.0
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 742500
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  raw,
    output logic level,
    output logic press
);

    localparam int                 c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_differs;
    logic               w_flip;

    assign w_differs = (raw != r_level);
    assign w_flip    = w_differs && (r_cnt == c_CNT_LAST);

    // Counter restarts on any sample that agrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (w_flip) begin
            r_level <= raw;
            r_cnt   <= '0;
        end else if (w_differs) begin
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
        end
    end

    assign level = r_level;
    assign press = w_flip && raw;

endmodule
`default_nettype wire

// File: rtl/video_path_select.sv
`default_nettype none
// ============================================================================
// Module  : video_path_select
// Brief   : Button-driven mode selection, committed to the mux only at frame edges.
// Revision: 1.0
// ============================================================================
module video_path_select
    import video_path_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 742500,
    parameter int TIMEOUT_CYCLES    = 2000000,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input wire                   clk,
    input wire                   rst_n,
    video_path_select_if.master  bus
);

    localparam int              c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        r_next_sync;
    logic [1:0]        r_prev_sync;
    logic              w_next_level;
    logic              w_prev_level;
    logic              w_next_press;
    logic              w_prev_press;
    logic              w_next_evt;
    logic              w_prev_evt;
    logic              r_vsync_q;
    logic              w_frame_edge;
    logic [3:0]        r_target;
    logic [3:0]        r_committed;
    logic [3:0]        r_adres;
    logic              r_commit_pulse;
    logic [c_TO_W-1:0] r_to_cnt;
    path_state_t       r_state;
    path_state_t       w_state_nxt;
    logic              w_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_sync <= 2'b00;
            r_prev_sync <= 2'b00;
            r_vsync_q   <= 1'b0;
        end else begin
            r_next_sync <= {r_next_sync[0], bus.btn_next};
            r_prev_sync <= {r_prev_sync[0], bus.btn_prev};
            r_vsync_q   <= bus.v_sync_in;
        end
    end

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (r_next_sync[1]),
        .level (w_next_level),
        .press (w_next_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (r_prev_sync[1]),
        .level (w_prev_level),
        .press (w_prev_press)
    );

    assign w_next_evt   = w_next_press && !w_next_level;
    assign w_prev_evt   = w_prev_press && !w_prev_level;
    assign w_frame_edge = VSYNC_ACTIVE_HIGH ? (bus.v_sync_in && !r_vsync_q)
                                            : (!bus.v_sync_in && r_vsync_q);

    // Simultaneous next and prev cancel each other out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= 4'd0;
        end else if (w_next_evt && !w_prev_evt) begin
            r_target <= (r_target == MODE_MAX) ? 4'd0 : r_target + 4'd1;
        end else if (w_prev_evt && !w_next_evt) begin
            r_target <= (r_target == 4'd0) ? MODE_MAX : r_target - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_target != r_committed) w_state_nxt = PENDING;
            end
            PENDING: begin
                if (r_target == r_committed) begin
                    w_state_nxt = IDLE;
                end else if (w_frame_edge || (r_to_cnt == c_TO_LAST)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_to_cnt       <= '0;
            r_committed    <= 4'd0;
            r_adres        <= 4'b0000;
            r_commit_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_commit_pulse <= w_commit;
            if (r_state == PENDING && w_state_nxt == PENDING) begin
                if (r_to_cnt != c_TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_commit) begin
                r_committed <= r_target;
                r_adres     <= mode_to_adres(r_target);
            end
        end
    end

    assign bus.adres_out    = r_adres;
    assign bus.mode_idx     = r_committed;
    assign bus.pending      = (r_state == PENDING);
    assign bus.commit_pulse = r_commit_pulse;

endmodule
`default_nettype wire

// File: tb/tb_video_path_select.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_path_select
// Brief   : Random button/frame stimulus against a mode-level reference model.
// Revision: 1.0
// ============================================================================
module tb_video_path_select;

    localparam int c_DEB = 4;
    localparam int c_TO  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    video_path_select_if bus();

    video_path_select #(
        .DEBOUNCE_CYCLES   (c_DEB),
        .TIMEOUT_CYCLES    (c_TO),
        .VSYNC_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;
    int pulse_cnt  = 0;
    int m_target   = 0;
    int m_committed = 0;
    int m_pulses   = 0;
    int adres_tbl [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 4'b1010, 4'b1001, 4'b1011, 4'b1111};

    always @(posedge clk) if (rst_n && bus.commit_pulse === 1'b1) pulse_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_adres"}, int'(bus.adres_out), adres_tbl[m_committed]);
        check_val({tag, "_mode"}, int'(bus.mode_idx), m_committed);
        check_val({tag, "_pending"}, int'(bus.pending), int'(m_target != m_committed));
        check_val({tag, "_pulses"}, pulse_cnt, m_pulses);
    endtask

    // sel: 0 next, 1 prev, 2 both together
    task automatic press(input int sel);
        bus.btn_next = (sel != 1);
        bus.btn_prev = (sel != 0);
        tick(7);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        tick(8);
        if (sel == 0) m_target = (m_target + 1) % 13;
        if (sel == 1) m_target = (m_target + 12) % 13;
    endtask

    task automatic bounce(input int sel);
        for (int i = 0; i < 4; i++) begin
            if (sel == 0) bus.btn_next = 1'b1; else bus.btn_prev = 1'b1;
            tick(3);
            bus.btn_next = 1'b0;
            bus.btn_prev = 1'b0;
            tick(2);
        end
        tick(6);
    endtask

    task automatic frame_edge();
        int chg;
        chg = int'(m_target != m_committed);
        bus.v_sync_in = 1'b1;
        @(negedge clk);
        if (chg != 0) begin
            m_committed = m_target;
            m_pulses++;
        end
        check_val("fe_pulse", int'(bus.commit_pulse), chg);
        check_val("fe_adres", int'(bus.adres_out), adres_tbl[m_committed]);
        tick(3);
        bus.v_sync_in = 1'b0;
        tick(3);
        check_val("fe_pulse_end", int'(bus.commit_pulse), 0);
    endtask

    task automatic idle_wait();
        tick(c_TO + 16);
        if (m_target != m_committed) begin
            m_committed = m_target;
            m_pulses++;
        end
    endtask

    initial begin
        int first_pend;
        bus.btn_next  = 1'b0;
        bus.btn_prev  = 1'b0;
        bus.v_sync_in = 1'b0;
        tick(3);
        check_val("rst_adres", int'(bus.adres_out), 0);
        check_val("rst_pulse", int'(bus.commit_pulse), 0);
        rst_n = 1'b1;
        tick(2);
        check_state("rst");

        // Frames with no button activity must never commit.
        for (int i = 0; i < 3; i++) begin
            bus.v_sync_in = 1'b1;
            tick(50);
            bus.v_sync_in = 1'b0;
            tick(50);
        end
        check_state("idle_frames");

        // Press latency and frame-aligned commit.
        first_pend = -1;
        bus.btn_next = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.pending === 1'b1 && first_pend < 0) first_pend = k;
            if (k == 7) bus.btn_next = 1'b0;
        end
        check_val("pend_latency_in_6_to_8", int'(first_pend >= 6 && first_pend <= 8), 1);
        m_target = 1;
        tick(5);
        check_state("before_edge");
        frame_edge();
        check_state("commit1");

        // Wrap downwards 1 -> 0 -> 12, then upwards 12 -> 0.
        press(1);
        press(1);
        check_state("wrap_down_pend");
        frame_edge();
        check_state("wrap_down");
        press(0);
        frame_edge();
        check_state("wrap_up");

        // No frame edges: forced commit after the timeout.
        press(0);
        idle_wait();
        check_state("timeout");

        while (m_committed != 8) begin
            press(0);
            frame_edge();
        end
        press(0);
        press(0);
        press(1);
        frame_edge();
        check_state("idx9");
        press(0);
        frame_edge();
        check_state("idx10");

        press(2);
        check_state("both");
        bounce(0);
        check_state("bounce");

        for (int it = 0; it < 25; it++) begin
            int k;
            k = $urandom_range(1, 2);
            for (int a = 0; a < k; a++) begin
                int kind;
                kind = $urandom_range(0, 3);
                if (kind == 3) bounce($urandom_range(0, 1));
                else press(kind);
            end
            check_state("rnd_pre");
            if ($urandom_range(0, 3) == 0) idle_wait();
            else frame_edge();
            check_state("rnd_post");
        end

        // Asynchronous reset discards a pending change (committed 2, target 5).
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        m_target = 0;
        m_committed = 0;
        tick(2);
        press(0);
        press(0);
        frame_edge();
        check_state("pre_rst2");
        press(0);
        press(0);
        press(0);
        check_state("pre_rst5");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_adres", int'(bus.adres_out), 0);
        check_val("async_pending", int'(bus.pending), 0);
        check_val("async_mode", int'(bus.mode_idx), 0);
        m_target = 0;
        m_committed = 0;
        tick(2);
        rst_n = 1'b1;
        frame_edge();
        tick(c_TO + 16);
        check_state("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
